can_msg_fifo: RTL

Parametrised Tx/Rx message buffer for the CAN controller. It sits between the host register interface and the bit-stream engine. It generalises the earlier two-entry FIFO with:
- arbitrary depth
- an occupancy count
- programmable almost-full/almost-empty flags
- sticky, clearable error flags
- synchronous flush
- selectable standard or first-word-fall-through (FWFT) read mode

---
 rtl/can_fifo_pkg.sv | 20 ++
 rtl/can_fifo_ram.sv | 23 ++
 rtl/can_msg_fifo.sv | 136 +++++++++++++
 3 files changed

// File: rtl/can_fifo_pkg.sv
// Shared definitions for the CAN message buffer: frame layout and pointer helpers.
package can_fifo_pkg;

  localparam int CAN_FRAME_W = 128;

  typedef struct packed {
    logic [28:0] pad;
    logic [28:0] id;
    logic        ide;
    logic        rtr;
    logic [3:0]  dlc;
    logic [63:0] data;
  } can_frame_t;

  // Advance a ring pointer, wrapping at depth-1 so non power-of-two depths work.
  function automatic int ptr_inc(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/can_fifo_ram.sv
// Simple dual-port storage array: synchronous write, asynchronous read.
module can_fifo_ram #(
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 8
) (
  input  logic                     i_sys_clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0]    i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0]    o_rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset so it maps onto RAM/LUT storage; validity is tracked by the count.
  always_ff @(posedge i_sys_clk) begin
    if (i_we) mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/can_msg_fifo.sv
// Parametrised Tx/Rx CAN message FIFO with occupancy, threshold flags, sticky errors,
// synchronous flush and standard or first-word-fall-through read.
module can_msg_fifo
  import can_fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = CAN_FRAME_W,
  parameter int DEPTH         = 8,
  parameter int FWFT          = 0,
  parameter int AFULL_THRESH  = DEPTH - 1,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic                         i_sys_clk,
  input  logic                         i_reset,
  input  logic                         i_flush,
  input  logic                         i_clr_err,
  input  logic                         i_wr_en,
  input  logic [DATA_WIDTH-1:0]        i_fifo_w_data,
  input  logic                         i_r_en,
  output logic [DATA_WIDTH-1:0]        o_fifo_r_data,
  output logic                         o_r_valid,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_full,
  output logic                         o_empty,
  output logic                         o_almost_full,
  output logic                         o_almost_empty,
  output logic                         o_overflow,
  output logic                         o_underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AEMPT_CNT = CW'(AEMPTY_THRESH);

  if (DEPTH < 2) begin : g_chk_depth
    $error("can_msg_fifo: DEPTH must be >= 2");
  end
  if (AFULL_THRESH > DEPTH) begin : g_chk_afull
    $error("can_msg_fifo: AFULL_THRESH must be <= DEPTH");
  end
  if (AEMPTY_THRESH >= DEPTH) begin : g_chk_aempty
    $error("can_msg_fifo: AEMPTY_THRESH must be < DEPTH");
  end

  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;
  logic                  overflow_q, underflow_q;
  logic                  empty, full;
  logic                  rd_acc, wr_acc;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

  // A full FIFO still takes a write when a read frees a slot on the same edge.
  assign rd_acc = i_r_en & ~empty;
  assign wr_acc = i_wr_en & (~full | rd_acc);
  assign mem_we = wr_acc & ~i_flush & ~i_reset;

  can_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .i_sys_clk (i_sys_clk),
    .i_we      (mem_we),
    .i_waddr   (wr_ptr),
    .i_wdata   (i_fifo_w_data),
    .i_raddr   (rd_ptr),
    .o_rdata   (ram_rdata)
  );

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge i_sys_clk) begin
    if (i_reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (i_flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (wr_acc) wr_ptr <= PW'(ptr_inc(int'(wr_ptr), DEPTH));
        if (rd_acc) rd_ptr <= PW'(ptr_inc(int'(rd_ptr), DEPTH));
        case ({wr_acc, rd_acc})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end

      // Set beats clear; requests swallowed by a flush never raise an error.
      if (i_wr_en & ~wr_acc & ~i_flush) overflow_q <= 1'b1;
      else if (i_clr_err)               overflow_q <= 1'b0;
      if (i_r_en & ~rd_acc & ~i_flush)  underflow_q <= 1'b1;
      else if (i_clr_err)               underflow_q <= 1'b0;
    end
  end

  if (FWFT != 0) begin : g_fwft
    assign o_r_valid     = ~empty;
    assign o_fifo_r_data = empty ? '0 : ram_rdata;
  end else begin : g_std
    logic                  r_valid_q;
    logic [DATA_WIDTH-1:0] r_data_q;

    always_ff @(posedge i_sys_clk) begin
      if (i_reset) begin
        r_valid_q <= 1'b0;
        r_data_q  <= '0;
      end else if (i_flush) begin
        r_valid_q <= 1'b0;
      end else begin
        r_valid_q <= rd_acc;
        if (rd_acc) r_data_q <= ram_rdata;
      end
    end

    assign o_r_valid     = r_valid_q;
    assign o_fifo_r_data = r_data_q;
  end

  assign o_count        = count;
  assign o_full         = full;
  assign o_empty        = empty;
  assign o_almost_full  = (count >= AFULL_CNT);
  assign o_almost_empty = (count <= AEMPT_CNT);
  assign o_overflow     = overflow_q;
  assign o_underflow    = underflow_q;

endmodule
